// File: rtl/vga_timing_gen.sv
// VGA scan timing generator: pixel divider, x/y counters, sync decode, and an
// alignment pipeline that lines sync/blanking up with the colour returned by the drawing logic.
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 2,
   parameter int COLOR_LAT = 1,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [3:0]  in_red,
   input  logic [3:0]  in_green,
   input  logic [3:0]  in_blue,
   output logic [10:0] pxl_x,
   output logic [9:0]  pxl_y,
   output logic        active,
   output logic        pxl_tick,
   output logic        frame_start,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [10:0]      x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             fs_q, fs_d;
   logic             first_q, first_d;
   logic             tick;
   logic             hs_raw, vs_raw, de_raw;

   assign tick = (div_q == DIV_LAST);

   // first_q marks the clock right after reset so the first frame also gets its pulse
   always_comb begin
      div_d   = tick ? '0 : div_q + 1'b1;
      x_d     = x_q;
      y_d     = y_q;
      first_d = 1'b0;
      fs_d    = first_q | (tick && (x_q == H_LAST) && (y_q == V_LAST));
      if (tick) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         div_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         fs_q    <= 1'b0;
         first_q <= 1'b1;
      end else begin
         div_q   <= div_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fs_q    <= fs_d;
         first_q <= first_d;
      end
   end

   assign de_raw = (x_q < H_ACT) && (y_q < V_ACT);
   assign hs_raw = ((x_q >= HS_START) && (x_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
   assign vs_raw = ((y_q >= VS_START) && (y_q < VS_END)) ? SYNC_POL : ~SYNC_POL;

   logic hs_dly, vs_dly, de_dly;

   generate
      if (COLOR_LAT == 0) begin : g_bypass
         assign hs_dly = hs_raw;
         assign vs_dly = vs_raw;
         assign de_dly = de_raw;
      end else begin : g_pipe
         logic [COLOR_LAT-1:0] hs_sr_q, hs_sr_d;
         logic [COLOR_LAT-1:0] vs_sr_q, vs_sr_d;
         logic [COLOR_LAT-1:0] de_sr_q, de_sr_d;

         always_comb begin
            hs_sr_d    = hs_sr_q << 1;
            vs_sr_d    = vs_sr_q << 1;
            de_sr_d    = de_sr_q << 1;
            hs_sr_d[0] = hs_raw;
            vs_sr_d[0] = vs_raw;
            de_sr_d[0] = de_raw;
         end

         always_ff @(posedge clk) begin
            if (!resetN) begin
               hs_sr_q <= {COLOR_LAT{~SYNC_POL}};
               vs_sr_q <= {COLOR_LAT{~SYNC_POL}};
               de_sr_q <= '0;
            end else begin
               hs_sr_q <= hs_sr_d;
               vs_sr_q <= vs_sr_d;
               de_sr_q <= de_sr_d;
            end
         end

         assign hs_dly = hs_sr_q[COLOR_LAT-1];
         assign vs_dly = vs_sr_q[COLOR_LAT-1];
         assign de_dly = de_sr_q[COLOR_LAT-1];
      end
   endgenerate

   logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic       hs_q, hs_d, vs_q, vs_d;

   always_comb begin
      r_d  = de_dly ? in_red   : 4'h0;
      g_d  = de_dly ? in_green : 4'h0;
      b_d  = de_dly ? in_blue  : 4'h0;
      hs_d = hs_dly;
      vs_d = vs_dly;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
         hs_q <= ~SYNC_POL;
         vs_q <= ~SYNC_POL;
      end else begin
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
      end
   end

   assign pxl_x       = x_q;
   assign pxl_y       = y_q;
   assign active      = de_raw;
   assign pxl_tick    = tick;
   assign frame_start = fs_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster: instance A (CLK_DIV=2, COLOR_LAT=1),
// instance B (CLK_DIV=1, COLOR_LAT=3); pins are checked through per-instance scoreboards.
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2, HT = HA + HFP + HS + HBP;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;

   typedef struct {
      int x; int y; int act; int hs; int vs; int tick; int fs;
   } pix_t;

   typedef struct {
      int run; int x; int y; int fs;
   } vec_t;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic started = 1'b0;
   int   n = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [3:0]  in_red_a, in_green_a, in_blue_a;
   logic [10:0] pxl_x_a;
   logic [9:0]  pxl_y_a;
   logic        active_a, pxl_tick_a, frame_start_a, vga_hs_a, vga_vs_a;
   logic [3:0]  vga_r_a, vga_g_a, vga_b_a;

   logic [3:0]  in_red_b = 4'h0, in_green_b = 4'h0, in_blue_b = 4'h0;
   logic [10:0] pxl_x_b;
   logic [9:0]  pxl_y_b;
   logic        active_b, pxl_tick_b, frame_start_b, vga_hs_b, vga_vs_b;
   logic [3:0]  vga_r_b, vga_g_b, vga_b_b;

   logic [13:0] q_a[$];
   logic [13:0] q_b[$];

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CLK_DIV(2), .COLOR_LAT(1), .SYNC_POL(1'b0)
   ) dut_a (
      .clk(clk), .resetN(resetN),
      .in_red(in_red_a), .in_green(in_green_a), .in_blue(in_blue_a),
      .pxl_x(pxl_x_a), .pxl_y(pxl_y_a), .active(active_a), .pxl_tick(pxl_tick_a),
      .frame_start(frame_start_a), .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
      .vga_hs(vga_hs_a), .vga_vs(vga_vs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CLK_DIV(1), .COLOR_LAT(3), .SYNC_POL(1'b0)
   ) dut_b (
      .clk(clk), .resetN(resetN),
      .in_red(in_red_b), .in_green(in_green_b), .in_blue(in_blue_b),
      .pxl_x(pxl_x_b), .pxl_y(pxl_y_b), .active(active_b), .pxl_tick(pxl_tick_b),
      .frame_start(frame_start_b), .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
      .vga_hs(vga_hs_b), .vga_vs(vga_vs_b)
   );

   // Reference raster from the number of clocks since reset release
   function automatic pix_t model(input int nn, input int div);
      pix_t m;
      int   p;
      p      = nn / div;
      m.x    = p % HT;
      m.y    = (p / HT) % VT;
      m.act  = (m.x < HA && m.y < VA) ? 1 : 0;
      m.hs   = (m.x >= HA + HFP && m.x < HA + HFP + HS) ? 0 : 1;
      m.vs   = (m.y >= VA + VFP && m.y < VA + VFP + VS) ? 0 : 1;
      m.tick = ((nn % div) == div - 1) ? 1 : 0;
      m.fs   = (nn == 1 || (nn > 0 && (nn % (div * HT * VT)) == 0)) ? 1 : 0;
      return m;
   endfunction

   function automatic logic [13:0] pins(input logic [3:0] r, input logic [3:0] g,
                                        input logic [3:0] b, input int hs, input int vs);
      return {r, g, b, 1'(hs), 1'(vs)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s at t=%0t n=%0d: got 0x%0h expected 0x%0h", name, $time, n, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (!resetN) n <= 0;
      else         n <= n + 1;
      started <= 1'b1;
   end

   // Instance A: constant colour, pins expected two clocks after the source pixel
   always @(negedge clk) begin
      if (started) begin
         pix_t m;
         logic [13:0] e;
         m = model(n, 2);
         if (n == 0) begin
            q_a.delete();
            repeat (2) q_a.push_back(pins(4'h0, 4'h0, 4'h0, 1, 1));
         end
         chk("a_x", int'(pxl_x_a), m.x);
         chk("a_y", int'(pxl_y_a), m.y);
         chk("a_active", int'(active_a), m.act);
         chk("a_tick", int'(pxl_tick_a), m.tick);
         chk("a_frame_start", int'(frame_start_a), m.fs);
         if (m.act == 1) q_a.push_back(pins(4'hF, 4'hA, 4'h5, m.hs, m.vs));
         else            q_a.push_back(pins(4'h0, 4'h0, 4'h0, m.hs, m.vs));
         e = q_a.pop_front();
         chk("a_pins", int'(pins(vga_r_a, vga_g_a, vga_b_a, int'(vga_hs_a), int'(vga_vs_a))), int'(e));
      end
   end

   // Instance B: colour = coordinates of the pixel three clocks back, pins expected four clocks later
   always @(negedge clk) begin
      if (started) begin
         pix_t m;
         pix_t src;
         logic [13:0] e;
         logic [10:0] xs;
         logic [9:0]  ys;
         m = model(n, 1);
         if (n == 0) begin
            q_b.delete();
            repeat (4) q_b.push_back(pins(4'h0, 4'h0, 4'h0, 1, 1));
         end
         chk("b_x", int'(pxl_x_b), m.x);
         chk("b_y", int'(pxl_y_b), m.y);
         chk("b_tick", int'(pxl_tick_b), m.tick);
         chk("b_frame_start", int'(frame_start_b), m.fs);
         xs = 11'(m.x);
         ys = 10'(m.y);
         if (m.act == 1) q_b.push_back(pins(xs[3:0], ys[3:0], ~xs[3:0], m.hs, m.vs));
         else            q_b.push_back(pins(4'h0, 4'h0, 4'h0, m.hs, m.vs));
         e = q_b.pop_front();
         chk("b_pins", int'(pins(vga_r_b, vga_g_b, vga_b_b, int'(vga_hs_b), int'(vga_vs_b))), int'(e));
         if (n >= 3) begin
            src = model(n - 3, 1);
            xs  = 11'(src.x);
            ys  = 10'(src.y);
            in_red_b   = xs[3:0];
            in_green_b = ys[3:0];
            in_blue_b  = ~xs[3:0];
         end else begin
            in_red_b   = 4'h0;
            in_green_b = 4'h0;
            in_blue_b  = 4'h0;
         end
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clk);
      resetN = 1'b0;
      repeat (cycles) @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int hs_lo, vs_lo, col_on, fs_cnt;

      vecs[0] = '{run: 0,   x: 0,  y: 0, fs: 0};
      vecs[1] = '{run: 1,   x: 0,  y: 0, fs: 1};
      vecs[2] = '{run: 2,   x: 1,  y: 0, fs: 0};
      vecs[3] = '{run: 29,  x: 14, y: 0, fs: 0};
      vecs[4] = '{run: 30,  x: 0,  y: 1, fs: 0};
      vecs[5] = '{run: 239, x: 14, y: 7, fs: 0};
      vecs[6] = '{run: 240, x: 0,  y: 0, fs: 1};
      vecs[7] = '{run: 241, x: 0,  y: 0, fs: 0};

      in_red_a   = 4'hF;
      in_green_a = 4'hA;
      in_blue_a  = 4'h5;

      do_reset(3);
      chk("rst_x", int'(pxl_x_a), 0);
      chk("rst_y", int'(pxl_y_a), 0);
      chk("rst_pins", int'(pins(vga_r_a, vga_g_a, vga_b_a, int'(vga_hs_a), int'(vga_vs_a))),
          int'(pins(4'h0, 4'h0, 4'h0, 1, 1)));
      chk("rst_frame_start", int'(frame_start_a), 0);

      for (int i = 0; i < 8; i++) begin
         do_reset(3);
         repeat (vecs[i].run) @(negedge clk);
         chk("vec_x", int'(pxl_x_a), vecs[i].x);
         chk("vec_y", int'(pxl_y_a), vecs[i].y);
         chk("vec_fs", int'(frame_start_a), vecs[i].fs);
         $display("vec %0d: run=%0d x=%0d y=%0d fs=%0d", i, vecs[i].run,
                  pxl_x_a, pxl_y_a, frame_start_a);
      end

      // One whole frame of pins, starting where the first pixel reaches the DAC
      do_reset(3);
      repeat (2) @(negedge clk);
      hs_lo = 0; vs_lo = 0; col_on = 0; fs_cnt = 0;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         if (!vga_hs_a) hs_lo++;
         if (!vga_vs_a) vs_lo++;
         if (vga_r_a == 4'hF && vga_g_a == 4'hA && vga_b_a == 4'h5) col_on++;
         if (frame_start_a) fs_cnt++;
         @(negedge clk);
      end
      chk("frame_hs_low_clks", hs_lo, 48);
      chk("frame_vs_low_clks", vs_lo, 60);
      chk("frame_lit_clks", col_on, 64);
      chk("frame_fs_pulses", fs_cnt, 1);
      $display("frame: hs_low=%0d vs_low=%0d lit=%0d fs=%0d", hs_lo, vs_lo, col_on, fs_cnt);

      // Mid-frame single-clock reset at pixel (10,5)
      do_reset(3);
      repeat (170) @(negedge clk);
      chk("mid_x_before", int'(pxl_x_a), 10);
      chk("mid_y_before", int'(pxl_y_a), 5);
      resetN = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      chk("mid_x_after", int'(pxl_x_a), 0);
      chk("mid_y_after", int'(pxl_y_a), 0);
      chk("mid_pins_after", int'(pins(vga_r_a, vga_g_a, vga_b_a, int'(vga_hs_a), int'(vga_vs_a))),
          int'(pins(4'h0, 4'h0, 4'h0, 1, 1)));
      chk("mid_fs_in_reset", int'(frame_start_a), 0);
      @(negedge clk);
      chk("mid_fs_release", int'(frame_start_a), 1);
      @(negedge clk);
      chk("mid_fs_single", int'(frame_start_a), 0);
      $display("mid-frame reset: x=%0d y=%0d", pxl_x_a, pxl_y_a);

      repeat (300) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
